// File: rtl/sec_mask_pkg.sv
// Shared definitions for the serial masked gadgets: FSM encoding, randomness
// budget of an N-share DOM-AND and the A2B conversion latency.
package sec_mask_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } a2b_state_e;

   function automatic int rand_and(input int n);
      return n * (n - 1) / 2;
   endfunction

   function automatic int a2b_serial_lat(input int k, input int n);
      return (n - 1) * k + 1;
   endfunction

   // Index of the shared random bit for the cross-domain pair (i, j), i < j.
   function automatic int pair_idx(input int i, input int j, input int n);
      return i * n - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

endpackage

// File: rtl/sec_dom_and_reg.sv
// N-share 1-bit DOM-AND. Every inner and cross-domain product is registered
// before compression, so q appears one enabled cycle after a/b/rnd.
module sec_dom_and_reg
   import sec_mask_pkg::*;
#(
   parameter int N_SHARES = 3,
   parameter int RANDNUM  = rand_and(N_SHARES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [N_SHARES-1:0] a,
   input  logic [N_SHARES-1:0] b,
   input  logic [RANDNUM-1:0]  rnd,
   output logic [N_SHARES-1:0] q
);

   logic [N_SHARES*N_SHARES-1:0] term;
   logic [N_SHARES*N_SHARES-1:0] term_nxt;

   // Products a_i&b_j; the pair (i,j) and (j,i) share one fresh random bit.
   always_comb begin
      term_nxt = '0;
      for (int i = 0; i < N_SHARES; i++) begin
         for (int j = 0; j < N_SHARES; j++) begin
            if (i == j) begin
               term_nxt[i*N_SHARES+j] = a[i] & b[i];
            end else if (i < j) begin
               term_nxt[i*N_SHARES+j] = (a[i] & b[j]) ^ rnd[pair_idx(i, j, N_SHARES)];
            end else begin
               term_nxt[i*N_SHARES+j] = (a[i] & b[j]) ^ rnd[pair_idx(j, i, N_SHARES)];
            end
         end
      end
   end

   // Term register: the resharing barrier between domains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         term <= '0;
      end else if (ena) begin
         term <= term_nxt;
      end
   end

   // Per-domain compression of the registered terms.
   always_comb begin
      q = '0;
      for (int i = 0; i < N_SHARES; i++) begin
         q[i] = ^term[i*N_SHARES +: N_SHARES];
      end
   end

endmodule

// File: rtl/sec_a2b_serial.sv
// Bit-serial arithmetic-to-Boolean mask conversion: shares 1..N-1 are added one
// bit per cycle into a Boolean-masked accumulator through a masked ripple adder.
module sec_a2b_serial
   import sec_mask_pkg::*;
#(
   parameter int K_WIDTH   = 32,
   parameter int N_SHARES  = 3,
   parameter int MASKWIDTH = K_WIDTH * N_SHARES,
   parameter int RANDNUM   = rand_and(N_SHARES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dvld,
   input  logic                 ena,
   input  logic [RANDNUM-1:0]   rnd,
   input  logic [MASKWIDTH-1:0] i_a,
   output logic [MASKWIDTH-1:0] o_b,
   output logic                 ovld
);

   localparam int OW = (N_SHARES - 1) * K_WIDTH;
   localparam int JW = $clog2(K_WIDTH);
   localparam int SW = $clog2(N_SHARES);

   a2b_state_e          state;
   a2b_state_e          state_nxt;
   logic [MASKWIDTH-1:0] breg;
   logic [OW-1:0]        opnd;
   logic [JW-1:0]        j;
   logic [SW-1:0]        s;
   logic [N_SHARES-1:0]  c_reg;
   logic [N_SHARES-1:0]  c_cur;
   logic [N_SHARES-1:0]  q;
   logic [N_SHARES-1:0]  x;
   logic [N_SHARES-1:0]  y;
   logic [N_SHARES-1:0]  sum_bit;
   logic                 last_bit;
   logic                 last_share;
   logic                 dom_en;

   // Accumulator shares rotate right each cycle, so bit j always sits at bit 0.
   // The registered AND makes c = q ^ c_reg; it is forced to 0 on each share's first bit.
   always_comb begin
      x = '0;
      for (int k = 0; k < N_SHARES; k++) begin
         x[k] = breg[k*K_WIDTH];
      end
      y         = '0;
      y[0]      = opnd[0];
      c_cur     = (j == '0) ? '0 : (q ^ c_reg);
      sum_bit   = x ^ y ^ c_cur;
      last_bit  = (j == JW'(K_WIDTH - 1));
      last_share = (s == SW'(N_SHARES - 1));
      dom_en    = ena & (state == RUN);
   end

   sec_dom_and_reg #(
      .N_SHARES (N_SHARES),
      .RANDNUM  (RANDNUM)
   ) u_dom_and (
      .clk (clk),
      .rst (rst),
      .ena (dom_en),
      .a   (x ^ c_cur),
      .b   (y ^ c_cur),
      .rnd (rnd),
      .q   (q)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (ena) begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dvld) state_nxt = RUN;
            else      state_nxt = IDLE;
         end
         RUN: begin
            if (last_bit && last_share) state_nxt = DONE;
            else                        state_nxt = RUN;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, serial masked addition, result publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         breg  <= '0;
         opnd  <= '0;
         j     <= '0;
         s     <= '0;
         c_reg <= '0;
         o_b   <= '0;
         ovld  <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               ovld <= 1'b0;
               if (dvld) begin
                  breg  <= {{(MASKWIDTH-K_WIDTH){1'b0}}, i_a[K_WIDTH-1:0]};
                  opnd  <= i_a[MASKWIDTH-1:K_WIDTH];
                  j     <= '0;
                  s     <= SW'(1);
                  c_reg <= '0;
               end
            end
            RUN: begin
               for (int k = 0; k < N_SHARES; k++) begin
                  breg[k*K_WIDTH +: K_WIDTH] <= {sum_bit[k], breg[k*K_WIDTH+1 +: K_WIDTH-1]};
               end
               opnd <= {1'b0, opnd[OW-1:1]};
               if (last_bit) begin
                  j     <= '0;
                  s     <= s + SW'(1);
                  c_reg <= '0;
               end else begin
                  j     <= j + JW'(1);
                  c_reg <= c_cur;
               end
            end
            DONE: begin
               o_b  <= breg;
               ovld <= 1'b1;
            end
            default: begin
               ovld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sec_a2b_serial.sv
// Directed self-checking bench for sec_a2b_serial at K=8, N=3.
module tb_sec_a2b_serial;

   localparam int K  = 8;
   localparam int N  = 3;
   localparam int MW = K * N;
   localparam int RN = N * (N - 1) / 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dvld = 1'b0;
   logic          ena = 1'b0;
   logic [RN-1:0] rnd = '0;
   logic [MW-1:0] i_a = '0;
   logic [MW-1:0] o_b;
   logic          ovld;

   int n_checks = 0;
   int n_fail   = 0;

   sec_a2b_serial #(.K_WIDTH(K), .N_SHARES(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .dvld (dvld),
      .ena  (ena),
      .rnd  (rnd),
      .i_a  (i_a),
      .o_b  (o_b),
      .ovld (ovld)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [K-1:0] recomb(input logic [MW-1:0] v);
      return v[7:0] ^ v[15:8] ^ v[23:16];
   endfunction

   function automatic logic [K-1:0] asum(input logic [MW-1:0] v);
      return v[7:0] + v[15:8] + v[23:16];
   endfunction

   // One conversion; lat counts enabled edges after the accepting edge up to ovld.
   task automatic run_conv(input logic [MW-1:0] a, input bit zero_rnd, input bit rand_ena,
                           output logic [MW-1:0] res, output int lat);
      int budget;
      i_a  = a;
      dvld = 1'b1;
      ena  = 1'b1;
      rnd  = RN'($urandom);
      step();
      dvld   = 1'b0;
      i_a    = MW'($urandom);
      lat    = 0;
      budget = 0;
      while (budget < 400) begin
         ena = rand_ena ? 1'($urandom_range(0, 1)) : 1'b1;
         rnd = zero_rnd ? '0 : RN'($urandom);
         step();
         budget++;
         if (ena) lat++;
         if (ovld) break;
      end
      if (!ovld) check("ovld_timeout", 32'(ovld), 32'd1);
      res = o_b;
   endtask

   logic [MW-1:0] res;
   logic [MW-1:0] res_z;
   logic [MW-1:0] a_in;
   int            lat;
   int            diffs;
   int            pulses;
   int            first_pulse;

   initial begin
      // Reset state.
      #2;
      check("reset_ob", 32'(o_b), 32'd0);
      check("reset_ovld", 32'(ovld), 32'd0);
      step();
      rst = 1'b0;
      ena = 1'b1;
      step();

      // Basic conversion and latency.
      run_conv({8'hD5, 8'h20, 8'h10}, 1'b0, 1'b0, res, lat);
      check("basic_lat", 32'(lat), 32'd17);
      check("basic_val", 32'(recomb(res)), 32'h05);
      step();
      check("ovld_one_cycle", 32'(ovld), 32'd0);
      repeat (4) step();
      check("ob_hold", 32'(recomb(o_b)), 32'h05);

      // Wrap-around.
      run_conv({8'h00, 8'h01, 8'hFF}, 1'b0, 1'b0, res, lat);
      check("wrap_00", 32'(recomb(res)), 32'h00);
      run_conv({8'hFF, 8'hFF, 8'hFF}, 1'b0, 1'b0, res, lat);
      check("wrap_fd", 32'(recomb(res)), 32'hFD);

      // rnd=0 versus random rnd.
      diffs = 0;
      for (int t = 0; t < 1000; t++) begin
         a_in = MW'($urandom);
         run_conv(a_in, 1'b1, 1'b0, res_z, lat);
         run_conv(a_in, 1'b0, 1'b0, res, lat);
         check("rnd0_sum", 32'(recomb(res_z)), 32'(asum(a_in)));
         check("rnd_sum", 32'(recomb(res)), 32'(asum(a_in)));
         if (res != res_z) diffs++;
      end
      check("rnd_remasks", 32'(diffs > 500), 32'd1);

      // dvld during RUN (cycle 3) and in DONE (cycle 17) is ignored.
      step();
      i_a  = {8'h03, 8'h02, 8'h71};
      dvld = 1'b1;
      step();
      pulses      = 0;
      first_pulse = 0;
      for (int c = 1; c <= 40; c++) begin
         dvld = (c == 3) || (c == 17);
         i_a  = (c == 3) ? {8'h11, 8'h22, 8'h33} : {8'h44, 8'h55, 8'h66};
         rnd  = RN'($urandom);
         step();
         if (ovld) begin
            pulses++;
            if (first_pulse == 0) first_pulse = c;
         end
      end
      dvld = 1'b0;
      check("dvld_pulses", 32'(pulses), 32'd1);
      check("dvld_pulse_at", 32'(first_pulse), 32'd17);
      check("dvld_value", 32'(recomb(o_b)), 32'h76);

      // Random ena gating; ovld held while frozen.
      run_conv({8'h81, 8'h77, 8'h3C}, 1'b0, 1'b1, res, lat);
      check("ena_lat", 32'(lat), 32'd17);
      check("ena_val", 32'(recomb(res)), 32'h34);
      ena = 1'b0;
      step();
      step();
      check("ena_hold_ovld", 32'(ovld), 32'd1);
      ena = 1'b1;
      step();
      check("ena_release_ovld", 32'(ovld), 32'd0);

      // Abort at RUN cycle 5 with reset.
      i_a  = {8'h66, 8'h55, 8'h44};
      dvld = 1'b1;
      step();
      dvld = 1'b0;
      repeat (5) step();
      rst = 1'b1;
      #1;
      check("abort_ob", 32'(o_b), 32'd0);
      check("abort_ovld", 32'(ovld), 32'd0);
      step();
      check("abort_ob_hold", 32'(o_b), 32'd0);
      rst    = 1'b0;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (ovld) pulses++;
      end
      check("abort_no_ovld", 32'(pulses), 32'd0);
      run_conv({8'h03, 8'h02, 8'h01}, 1'b0, 1'b0, res, lat);
      check("after_abort_lat", 32'(lat), 32'd17);
      check("after_abort_val", 32'(recomb(res)), 32'h06);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
